facto_driver: RTL

Bus-master sequencer that sits directly upstream of the factorial core and drives its slave port. It accepts factorial jobs on a valid/ready request channel and programs the core's registers. It then waits for the core's interrupt, reads back the 128-bit result and clears the core. Finally it returns the result, with an error flag, on a valid/ready response channel. It replaces hand-written register sequences in the testbench and the system bus master.

---
 rtl/facto_pkg.sv | 45 ++++
 rtl/facto_bus_if.sv | 22 ++
 rtl/facto_driver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/facto_pkg.sv
// Shared definitions for the factorial core and its bus-master driver:
// register map, driver FSM encoding and the one-cycle bus command record.
package facto_pkg;

  localparam logic [7:0] OFF_OPSTART  = 8'h00;
  localparam logic [7:0] OFF_OPCLEAR  = 8'h08;
  localparam logic [7:0] OFF_OPDONE   = 8'h10;
  localparam logic [7:0] OFF_INTREN   = 8'h18;
  localparam logic [7:0] OFF_OPERAND  = 8'h20;
  localparam logic [7:0] OFF_RESULT_H = 8'h28;
  localparam logic [7:0] OFF_RESULT_L = 8'h30;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SHORT, ST_W_IEN, ST_W_OPND, ST_W_START, ST_WAIT_IRQ, ST_R_HI,
    ST_CAP_HI, ST_R_LO, ST_CAP_LO, ST_W_CLR, ST_W_UNCLR, ST_W_UNST, ST_RESP
  } state_e;

  typedef struct packed {
    logic        go;
    logic        wr;
    logic [7:0]  offset;
    logic [63:0] data;
  } bus_cmd_t;

  localparam bus_cmd_t BUS_NOP = '0;

  function automatic bus_cmd_t bus_write(input logic [7:0] off, input logic [63:0] data);
    bus_cmd_t c;
    c.go     = 1'b1;
    c.wr     = 1'b1;
    c.offset = off;
    c.data   = data;
    return c;
  endfunction

  function automatic bus_cmd_t bus_read(input logic [7:0] off);
    bus_cmd_t c;
    c.go     = 1'b1;
    c.wr     = 1'b0;
    c.offset = off;
    c.data   = '0;
    return c;
  endfunction

endpackage

// File: rtl/facto_bus_if.sv
// Turns a bus command into a single-cycle slave access; every bus output is
// held at zero whenever no access is requested.
module facto_bus_if
  import facto_pkg::*;
#(
  parameter logic [7:0] BASE = 8'h00
) (
  input  bus_cmd_t    cmd_i,
  output logic        m_sel_o,
  output logic        m_wr_o,
  output logic [15:0] m_addr_o,
  output logic [63:0] m_dout_o
);

  always_comb begin
    m_sel_o  = cmd_i.go;
    m_wr_o   = cmd_i.go & cmd_i.wr;
    m_addr_o = cmd_i.go ? {BASE, cmd_i.offset} : 16'h0000;
    m_dout_o = (cmd_i.go && cmd_i.wr) ? cmd_i.data : 64'd0;
  end

endmodule

// File: rtl/facto_driver.sv
// Sequencer that programs the factorial core over its slave port, waits for
// the completion interrupt (bounded by TIMEOUT) and returns the 128-bit result.
module facto_driver
  import facto_pkg::*;
#(
  parameter logic [7:0] BASE    = 8'h00,
  parameter int         TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [63:0]  req_operand,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_result,
  output logic         rsp_error,
  output logic         m_sel,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_dout,
  input  logic [63:0]  m_din,
  input  logic         interrupt
);

  localparam int              CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    opnd_q, opnd_d;
  logic [127:0]   result_q, result_d;
  logic           error_q, error_d;
  bus_cmd_t       cmd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    error_d  = error_q;
    cmd      = BUS_NOP;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Payload is cleared here so a timed-out job reports a zero result.
          opnd_d   = req_operand;
          result_d = '0;
          error_d  = 1'b0;
          state_d  = (req_operand <= 64'd1) ? ST_SHORT : ST_W_IEN;
        end
      end
      ST_SHORT: begin
        result_d = 128'd1;
        state_d  = ST_RESP;
      end
      ST_W_IEN: begin
        cmd     = bus_write(OFF_INTREN, 64'd1);
        state_d = ST_W_OPND;
      end
      ST_W_OPND: begin
        cmd     = bus_write(OFF_OPERAND, opnd_q);
        state_d = ST_W_START;
      end
      ST_W_START: begin
        cmd     = bus_write(OFF_OPSTART, 64'd1);
        cnt_d   = '0;
        state_d = ST_WAIT_IRQ;
      end
      ST_WAIT_IRQ: begin
        // Interrupt is tested first so it beats a coincident timeout.
        if (interrupt) begin
          state_d = ST_R_HI;
        end else if (cnt_q == CNT_LAST) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = ST_W_CLR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_R_HI: begin
        cmd     = bus_read(OFF_RESULT_H);
        state_d = ST_CAP_HI;
      end
      ST_CAP_HI: begin
        result_d[127:64] = m_din;
        state_d          = ST_R_LO;
      end
      ST_R_LO: begin
        cmd     = bus_read(OFF_RESULT_L);
        state_d = ST_CAP_LO;
      end
      ST_CAP_LO: begin
        result_d[63:0] = m_din;
        state_d        = ST_W_CLR;
      end
      ST_W_CLR: begin
        cmd     = bus_write(OFF_OPCLEAR, 64'd1);
        state_d = ST_W_UNCLR;
      end
      ST_W_UNCLR: begin
        cmd     = bus_write(OFF_OPCLEAR, 64'd0);
        state_d = ST_W_UNST;
      end
      ST_W_UNST: begin
        cmd     = bus_write(OFF_OPSTART, 64'd0);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with reset_n keeps req_ready low for the whole reset interval.
  assign req_ready  = (state_q == ST_IDLE) && reset_n;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = result_q;
  assign rsp_error  = error_q;

  facto_bus_if #(
    .BASE(BASE)
  ) u_bus (
    .cmd_i    (cmd),
    .m_sel_o  (m_sel),
    .m_wr_o   (m_wr),
    .m_addr_o (m_addr),
    .m_dout_o (m_dout)
  );

endmodule
